// File: rtl/ins_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ins_fetch_queue_pkg
// Description : Shared defaults and state encoding for the instruction
//               prefetch queue and the CPU core it feeds.
// Revision    : 1.0 - initial release
// ============================================================================
package ins_fetch_queue_pkg;

    localparam int c_def_width    = 32;
    localparam int c_def_addrsize = 12;
    localparam int c_def_depth    = 4;
    localparam int c_def_cntw     = 3;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FULL  = 2'd1,
        S_REDIR = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/ins_fetch_queue_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO holding {addr, data} fetch entries, with
//               flush, occupancy count and a zeroed head when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DATA_W = 44,
    parameter int DEPTH  = 4,
    parameter int CNTW   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_head,
    output logic              o_valid,
    output logic [CNTW-1:0]   o_count
);

    localparam int              c_ptrw  = $clog2(DEPTH);
    localparam logic [CNTW-1:0] c_depth = CNTW'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_ptrw-1:0] r_wr_ptr;
    logic [c_ptrw-1:0] r_rd_ptr;
    logic [CNTW-1:0]   r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_valid   = (r_count != '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & o_valid;
    assign w_do_push = i_push & ~i_clear & ((r_count != c_depth) | w_do_pop);

    // Head reads as zero while empty so downstream never sees stale words
    assign o_head = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptrw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptrw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ins_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ins_fetch_queue
// Description : Sequential instruction prefetch queue with valid/ready head
//               and redirect flush, between instruction memory and the core.
// Revision    : 1.0 - initial release
// ============================================================================
module ins_fetch_queue
    import ins_fetch_queue_pkg::*;
#(
    parameter int WIDTH    = c_def_width,
    parameter int ADDRSIZE = c_def_addrsize,
    parameter int DEPTH    = c_def_depth,
    parameter int CNTW     = c_def_cntw
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fetch_en,
    input  logic                redirect,
    input  logic [ADDRSIZE-1:0] redirect_addr,
    output logic                ins_valid,
    input  logic                ins_ready,
    output logic [WIDTH-1:0]    ins_data,
    output logic [ADDRSIZE-1:0] ins_addr,
    output logic                imem_en,
    output logic [ADDRSIZE-1:0] imem_addr,
    input  logic [WIDTH-1:0]    imem_rdata,
    output logic [CNTW-1:0]     q_count
);

    localparam logic [CNTW-1:0] c_depth = CNTW'(DEPTH);

    fetch_state_t              r_state;
    fetch_state_t              w_state_nxt;
    logic [ADDRSIZE-1:0]       r_fetch_pc;
    logic [ADDRSIZE-1:0]       r_inflight_addr;
    logic                      r_inflight;
    logic                      r_drop;
    logic [CNTW-1:0]           w_occ;
    logic [CNTW-1:0]           w_count_nxt;
    logic [CNTW-1:0]           w_occ_nxt;
    logic                      w_credit_ok;
    logic                      w_issue;
    logic                      w_push;
    logic                      w_pop;
    logic [ADDRSIZE+WIDTH-1:0] w_head;

    // Queued words plus the outstanding read may never exceed the FIFO depth
    assign w_occ       = q_count + CNTW'(r_inflight);
    assign w_credit_ok = (w_occ < c_depth);

    // The recovery cycle already issues at the new address, so the first
    // post-redirect word is visible three cycles after the redirect.
    assign w_issue   = fetch_en & ~redirect & (r_state != S_FULL) & w_credit_ok;
    assign imem_en   = w_issue;
    assign imem_addr = r_fetch_pc;

    assign w_push = r_inflight & ~r_drop & ~redirect;
    assign w_pop  = ins_valid & ins_ready;

    always_comb begin
        w_count_nxt = q_count;
        if (redirect) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = q_count + CNTW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = q_count - CNTW'(1);
        end
        w_occ_nxt = w_count_nxt + CNTW'(w_issue);

        w_state_nxt = r_state;
        if (redirect) begin
            w_state_nxt = S_REDIR;
        end else begin
            case (r_state)
                S_RUN:   if (w_occ_nxt == c_depth) w_state_nxt = S_FULL;
                S_FULL:  if (w_occ_nxt < c_depth)  w_state_nxt = S_RUN;
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_RUN;
            r_fetch_pc      <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_drop          <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            // Any read outstanding across a redirect belongs to the old stream
            r_drop     <= redirect & r_inflight;
            if (redirect) begin
                r_fetch_pc <= redirect_addr;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + ADDRSIZE'(1);
            end
            if (w_issue) begin
                r_inflight_addr <= r_fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DATA_W (ADDRSIZE + WIDTH),
        .DEPTH  (DEPTH),
        .CNTW   (CNTW)
    ) u_fetch_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({r_inflight_addr, imem_rdata}),
        .i_pop       (w_pop),
        .i_clear     (redirect),
        .o_head      (w_head),
        .o_valid     (ins_valid),
        .o_count     (q_count)
    );

    assign ins_addr = w_head[WIDTH +: ADDRSIZE];
    assign ins_data = w_head[WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_ins_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ins_fetch_queue
// Description : Directed and randomized bench for ins_fetch_queue against a
//               queue-based reference model of the prefetch behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ins_fetch_queue;

    localparam int WIDTH    = 32;
    localparam int ADDRSIZE = 12;
    localparam int DEPTH    = 4;
    localparam int CNTW     = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                fetch_en;
    logic                redirect;
    logic [ADDRSIZE-1:0] redirect_addr;
    logic                ins_valid;
    logic                ins_ready;
    logic [WIDTH-1:0]    ins_data;
    logic [ADDRSIZE-1:0] ins_addr;
    logic                imem_en;
    logic [ADDRSIZE-1:0] imem_addr;
    logic [WIDTH-1:0]    imem_rdata;
    logic [CNTW-1:0]     q_count;

    always #5 clk = ~clk;

    ins_fetch_queue #(
        .WIDTH    (WIDTH),
        .ADDRSIZE (ADDRSIZE),
        .DEPTH    (DEPTH),
        .CNTW     (CNTW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .ins_valid     (ins_valid),
        .ins_ready     (ins_ready),
        .ins_data      (ins_data),
        .ins_addr      (ins_addr),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .q_count       (q_count)
    );

    function automatic logic [WIDTH-1:0] mem_word(input logic [ADDRSIZE-1:0] a);
        return WIDTH'(a) + WIDTH'(100);
    endfunction

    // Synchronous memory: data valid the cycle after the strobe, junk otherwise
    always @(posedge clk) begin
        if (imem_en === 1'b1) imem_rdata <= mem_word(imem_addr);
        else                  imem_rdata <= WIDTH'($urandom);
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: queued addresses, one outstanding read, next fetch pc
    logic [ADDRSIZE-1:0] m_q[$];
    bit                  m_pend;
    logic [ADDRSIZE-1:0] m_pend_addr;
    logic [ADDRSIZE-1:0] m_pc;
    bit                  m_known = 0;

    function automatic bit model_issue();
        return fetch_en && !redirect && ((m_q.size() + int'(m_pend)) < DEPTH);
    endfunction

    task automatic compare();
        logic [ADDRSIZE-1:0] ea;
        logic [WIDTH-1:0]    ed;
        ea = (m_q.size() != 0) ? m_q[0] : '0;
        ed = (m_q.size() != 0) ? mem_word(m_q[0]) : '0;
        check("imem_en",   64'(imem_en),   64'(model_issue()));
        check("imem_addr", 64'(imem_addr), 64'(m_pc));
        check("q_count",   64'(q_count),   64'(m_q.size()));
        check("ins_valid", 64'(ins_valid), 64'(m_q.size() != 0));
        check("ins_addr",  64'(ins_addr),  64'(ea));
        check("ins_data",  64'(ins_data),  64'(ed));
    endtask

    task automatic model_step();
        bit en;
        en = model_issue();
        if (rst) begin
            m_q.delete();
            m_pend  = 0;
            m_pc    = '0;
            m_known = 1;
        end else if (m_known) begin
            if (redirect) begin
                m_q.delete();
                m_pend = 0;
                m_pc   = redirect_addr;
            end else begin
                if (ins_ready && m_q.size() != 0) void'(m_q.pop_front());
                if (m_pend) m_q.push_back(m_pend_addr);
                m_pend      = en;
                m_pend_addr = m_pc;
                if (en) m_pc = m_pc + ADDRSIZE'(1);
            end
        end
    endtask

    // Inputs are changed at the falling edge; outputs compared just after
    task automatic tick();
        #1;
        if (m_known) compare();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1);
    end

    initial begin
        int guard;
        rst = 1'b1; fetch_en = 1'b1; redirect = 1'b0;
        redirect_addr = '0; ins_ready = 1'b1;
        @(negedge clk);
        repeat (2) tick();

        // Streaming from reset
        rst = 1'b0;
        repeat (10) tick();

        // Backpressure from reset: fill, hold, drain, resume at 4
        rst = 1'b1; tick();
        rst = 1'b0; ins_ready = 1'b0;
        repeat (10) tick();
        ins_ready = 1'b1;
        repeat (8) tick();

        // Redirect with three queued and one in flight
        rst = 1'b1; tick();
        rst = 1'b0; ins_ready = 1'b0;
        guard = 0;
        while (!(m_q.size() == 3 && m_pend) && guard < 50) begin tick(); guard++; end
        check("wait_q3_inflight", 64'(guard < 50), 64'(1));
        redirect = 1'b1; redirect_addr = 12'h020; tick();
        redirect = 1'b0; ins_ready = 1'b1;
        repeat (8) tick();

        // Address wrap
        redirect = 1'b1; redirect_addr = 12'd4094; tick();
        redirect = 1'b0;
        repeat (8) tick();

        // Fetch halted mid-stream
        fetch_en = 1'b0; repeat (5) tick();
        fetch_en = 1'b1; repeat (8) tick();

        // Back-to-back redirects
        redirect = 1'b1; redirect_addr = 12'h100; tick();
        redirect_addr = 12'h200; tick();
        redirect = 1'b0;
        repeat (6) tick();

        // Reset with two queued
        ins_ready = 1'b0;
        guard = 0;
        while (m_q.size() != 2 && guard < 50) begin tick(); guard++; end
        check("wait_q2", 64'(guard < 50), 64'(1));
        rst = 1'b1; tick();
        rst = 1'b0; ins_ready = 1'b1;
        repeat (6) tick();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            fetch_en      = ($urandom_range(0, 9) != 0);
            ins_ready     = ($urandom_range(0, 2) != 0);
            redirect      = ($urandom_range(0, 19) == 0);
            redirect_addr = ADDRSIZE'($urandom);
            rst           = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; redirect = 1'b0; fetch_en = 1'b1; ins_ready = 1'b1;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
